// File: rtl/eq_band_mixer.sv
// eq_band_mixer: per-channel POT-weighted sum of held band samples, saturated, volume-scaled, muteable.
// Latency: out_vld and new aud_out arrive NUM_CH*(NUM_BANDS+1)+1 cycles after an accepted smpl_vld.
// Backpressure: none; smpl_vld while busy is dropped and recorded in the sticky overrun flag.
module eq_band_mixer #(
  parameter int NUM_BANDS = 5,
  parameter int NUM_CH    = 2,
  parameter int DW        = 16,
  parameter int POT_W     = 12
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH*NUM_BANDS*DW-1:0] band_smpl,
  input  logic [NUM_BANDS-1:0]           band_vld,
  input  logic [NUM_BANDS*POT_W-1:0]     pot,
  input  logic [POT_W-1:0]               volume,
  input  logic                           mute,
  input  logic                           smpl_vld,
  output logic [NUM_CH*DW-1:0]           aud_out,
  output logic                           out_vld,
  output logic                           busy,
  output logic                           overrun
);

  // Product and accumulator widths; the accumulator has headroom for NUM_BANDS full-scale products.
  localparam int PW = DW + POT_W + 1;
  localparam int AW = PW + $clog2(NUM_BANDS);
  localparam int BW = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, VOL, DONE} state_t;

  state_t               state;
  logic [CW-1:0]        ch;
  logic [BW-1:0]        b;
  logic signed [AW-1:0] acc;

  logic signed [DW-1:0] hold     [NUM_CH][NUM_BANDS];
  logic signed [DW-1:0] hold_nxt [NUM_CH][NUM_BANDS];
  logic signed [DW-1:0] work     [NUM_CH][NUM_BANDS];
  logic [POT_W-1:0]     pot_work [NUM_BANDS];
  logic signed [DW-1:0] shadow   [NUM_CH];

  logic signed [DW-1:0] cur_smpl;
  logic [POT_W-1:0]     cur_pot;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] acc_nxt;
  logic signed [AW-1:0] acc_shr;
  logic signed [DW-1:0] mix;
  logic signed [PW-1:0] vprod;
  logic signed [DW-1:0] vol_res;
  logic                 unused_vbits;

  assign busy = (state != IDLE);

  // Next hold contents; a strobe in the snapshot cycle must land in the snapshot too.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < NUM_BANDS; i++) begin
        hold_nxt[c][i] = band_vld[i] ? band_smpl[(c*NUM_BANDS+i)*DW +: DW] : hold[c][i];
      end
    end
  end

  // Shared MAC and volume datapath for the current (ch, b) position.
  always_comb begin
    cur_smpl = work[ch][b];
    cur_pot  = pot_work[b];
    prod     = {{(PW-DW){cur_smpl[DW-1]}}, cur_smpl} * {{(PW-POT_W){1'b0}}, cur_pot};
    acc_nxt  = acc + {{(AW-PW){prod[PW-1]}}, prod};
    // pot = 2^(POT_W-1) is unity gain, so drop POT_W-1 fraction bits.
    acc_shr  = acc >>> (POT_W-1);
    if (acc_shr > SAT_MAX) begin
      mix = {1'b0, {(DW-1){1'b1}}};
    end else if (acc_shr < SAT_MIN) begin
      mix = {1'b1, {(DW-1){1'b0}}};
    end else begin
      mix = acc_shr[DW-1:0];
    end
    // Volume is below unity, so the floor-shifted product always fits in DW bits.
    vprod   = {{(PW-DW){mix[DW-1]}}, mix} * {{(PW-POT_W){1'b0}}, volume};
    vol_res = mute ? '0 : vprod[POT_W +: DW];
  end

  assign unused_vbits = ^{vprod[PW-1:POT_W+DW], vprod[POT_W-1:0]};

  // Band hold registers keep capturing while a mix runs; the mix reads only its snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          hold[c][i] <= '0;
        end
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        for (int i = 0; i < NUM_BANDS; i++) begin
          hold[c][i] <= hold_nxt[c][i];
        end
      end
    end
  end

  // Mix sequencer: snapshot, one MAC per cycle per band, one volume cycle per channel.
  // The output register loads on the last VOL cycle so out_vld coincides with the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ch      <= '0;
      b       <= '0;
      acc     <= '0;
      out_vld <= 1'b0;
      overrun <= 1'b0;
      aud_out <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        shadow[c] <= '0;
        for (int i = 0; i < NUM_BANDS; i++) begin
          work[c][i] <= '0;
        end
      end
      for (int i = 0; i < NUM_BANDS; i++) begin
        pot_work[i] <= '0;
      end
    end else begin
      out_vld <= 1'b0;
      if (smpl_vld && (state != IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (smpl_vld) begin
            for (int c = 0; c < NUM_CH; c++) begin
              for (int i = 0; i < NUM_BANDS; i++) begin
                work[c][i] <= hold_nxt[c][i];
              end
            end
            for (int i = 0; i < NUM_BANDS; i++) begin
              pot_work[i] <= pot[i*POT_W +: POT_W];
            end
            ch    <= '0;
            b     <= '0;
            acc   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc_nxt;
          if (b == BW'(NUM_BANDS-1)) begin
            state <= VOL;
          end else begin
            b <= b + 1'b1;
          end
        end
        VOL: begin
          shadow[ch] <= vol_res;
          if (ch == CW'(NUM_CH-1)) begin
            for (int c = 0; c < NUM_CH; c++) begin
              aud_out[c*DW +: DW] <= (c == NUM_CH-1) ? vol_res : shadow[c];
            end
            out_vld <= 1'b1;
            state   <= DONE;
          end else begin
            ch    <= ch + 1'b1;
            b     <= '0;
            acc   <= '0;
            state <= MAC;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: table vectors, hand-written timing sequences and random frames for eq_band_mixer.
// Expected values come from constant tables or an arithmetic model of the band mix.
// Inputs driven 1 time unit after the rising edge; outputs sampled there as well.
module tb_eq_band_mixer;

  localparam int NB   = 5;
  localparam int NC   = 2;
  localparam int DW   = 16;
  localparam int PWID = 12;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NC*NB*DW-1:0]   band_smpl;
  logic [NB-1:0]         band_vld;
  logic [NB*PWID-1:0]    pot;
  logic [PWID-1:0]       volume;
  logic                  mute;
  logic                  smpl_vld;
  logic [NC*DW-1:0]      aud_out;
  logic                  out_vld;
  logic                  busy;
  logic                  overrun;

  int n_cmp = 0;
  int n_err = 0;
  int m_hold [NC][NB];

  typedef struct {
    logic [NB*DW-1:0]   bl;
    logic [NB*DW-1:0]   br;
    logic [NB*PWID-1:0] pots;
    logic [PWID-1:0]    vol;
    logic               mt;
    logic [DW-1:0]      el;
    logic [DW-1:0]      er;
  } vec_t;

  vec_t tbl [5];

  eq_band_mixer #(.NUM_BANDS(NB), .NUM_CH(NC), .DW(DW), .POT_W(PWID)) dut (
    .clk       (clk),
    .rst       (rst),
    .band_smpl (band_smpl),
    .band_vld  (band_vld),
    .pot       (pot),
    .volume    (volume),
    .mute      (mute),
    .smpl_vld  (smpl_vld),
    .aud_out   (aud_out),
    .out_vld   (out_vld),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; the band hold model follows the inputs seen at that edge.
  task automatic step();
    for (int c = 0; c < NC; c++) begin
      for (int i = 0; i < NB; i++) begin
        if (rst) m_hold[c][i] = 0;
        else if (band_vld[i]) m_hold[c][i] = int'($signed(band_smpl[(c*NB+i)*DW +: DW]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Weighted sum, floor divide by unity gain, clamp, volume scale with floor, mute.
  function automatic logic [31:0] model_mix(input logic [NB*PWID-1:0] pv, input logic [PWID-1:0] vol,
                                            input logic m);
    logic [31:0] res;
    longint sum;
    longint mx;
    longint o;
    res = '0;
    for (int c = 0; c < NC; c++) begin
      sum = 0;
      for (int i = 0; i < NB; i++) begin
        sum += longint'(m_hold[c][i]) * longint'(pv[i*PWID +: PWID]);
      end
      mx = sum >>> 11;
      if (mx > 32767) mx = 32767;
      if (mx < -32768) mx = -32768;
      o = (mx * longint'(vol)) >>> 12;
      if (m) o = 0;
      res[c*DW +: DW] = o[15:0];
    end
    return res;
  endfunction

  // Caller sets cycle-0 inputs with smpl_vld=1; observes 20 cycles after the start.
  task automatic do_frame(input bit disturb, output int vcyc, output int npulse, output int bbad,
                          output logic [31:0] outv, output logic [31:0] expv);
    logic [NB*PWID-1:0] p0;
    logic [63:0] r64;
    p0 = pot;
    step();
    expv = model_mix(p0, volume, mute);
    smpl_vld = 1'b0;
    band_vld = '0;
    vcyc = -1;
    npulse = 0;
    bbad = 0;
    outv = '0;
    for (int k = 1; k <= 20; k++) begin
      if (out_vld) begin
        npulse++;
        if (vcyc < 0) begin
          vcyc = k;
          outv = aud_out;
        end
      end
      if (busy !== (k <= 13)) bbad++;
      if (disturb) begin
        band_vld  = NB'($urandom);
        band_smpl = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        r64 = {$urandom(), $urandom()};
        pot = r64[NB*PWID-1:0];
      end
      step();
    end
    band_vld = '0;
  endtask

  task automatic check_frame(input string tag, input int vcyc, input int npulse, input int bbad,
                             input logic [31:0] outv, input logic [31:0] expv);
    chk({tag, "_latency"}, vcyc, 13);
    chk({tag, "_pulses"}, npulse, 1);
    chk({tag, "_busy_window"}, bbad, 0);
    chk({tag, "_out"}, outv, expv);
  endtask

  initial begin
    int vc, np, bb, p13, p27, extra, c;
    logic [31:0] ov, ev;
    logic [63:0] r64;

    tbl[0] = '{bl: {16'h0, 16'h0, 16'h0, 16'h0, 16'h1000}, br: {16'h0, 16'h0, 16'h0, 16'h0, 16'hF000},
               pots: {5{12'h800}}, vol: 12'hFFF, mt: 1'b0, el: 16'h0FFF, er: 16'hF001};
    tbl[1] = '{bl: {5{16'h7000}}, br: {5{16'h9000}},
               pots: {5{12'hFFF}}, vol: 12'hFFF, mt: 1'b0, el: 16'h7FF7, er: 16'h8008};
    tbl[2] = '{bl: {5{16'h7000}}, br: {5{16'h9000}},
               pots: {5{12'hFFF}}, vol: 12'hFFF, mt: 1'b1, el: 16'h0000, er: 16'h0000};
    tbl[3] = '{bl: {16'h0, 16'h0, 16'h0, 16'h0100, 16'h0}, br: {16'h0, 16'hFF00, 16'h0, 16'h0, 16'h0},
               pots: {12'h800, 12'h800, 12'h800, 12'h400, 12'h800}, vol: 12'h800, mt: 1'b0,
               el: 16'h0040, er: 16'hFF80};
    tbl[4] = '{bl: {16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF}, br: {16'h0, 16'h0, 16'h0, 16'h0, 16'h0001},
               pots: {5{12'h800}}, vol: 12'h800, mt: 1'b0, el: 16'hFFFF, er: 16'h0000};

    // Reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      band_smpl = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      band_vld  = NB'($urandom);
      r64       = {$urandom(), $urandom()};
      pot       = r64[NB*PWID-1:0];
      volume    = PWID'($urandom);
      mute      = 1'($urandom);
      smpl_vld  = 1'($urandom);
      step();
    end
    chk("rst_aud_out", aud_out, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    rst = 1'b0;
    band_vld = '0;
    mute = 1'b0;
    volume = 12'hFFF;
    smpl_vld = 1'b1;
    do_frame(1'b0, vc, np, bb, ov, ev);
    check_frame("rst_first", vc, np, bb, ov, ev);
    chk("rst_first_zero", ov, 0);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      band_smpl = {tbl[i].br, tbl[i].bl};
      band_vld  = '1;
      step();
      band_vld  = '0;
      pot       = tbl[i].pots;
      volume    = tbl[i].vol;
      mute      = tbl[i].mt;
      smpl_vld  = 1'b1;
      do_frame(1'b0, vc, np, bb, ov, ev);
      chk($sformatf("vec%0d_latency", i), vc, 13);
      chk($sformatf("vec%0d_pulses", i), np, 1);
      chk($sformatf("vec%0d_L", i), ov[15:0], tbl[i].el);
      chk($sformatf("vec%0d_R", i), ov[31:16], tbl[i].er);
    end

    // Random frames with inputs disturbed during the mix
    for (int i = 0; i < 25; i++) begin
      band_smpl = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      band_vld  = NB'($urandom);
      step();
      band_smpl = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      band_vld  = NB'($urandom);
      r64       = {$urandom(), $urandom()};
      pot       = r64[NB*PWID-1:0];
      volume    = (i == 0) ? 12'h000 : (i == 1) ? 12'hFFF : PWID'($urandom);
      mute      = ($urandom_range(0, 7) == 0);
      smpl_vld  = 1'b1;
      do_frame(1'b1, vc, np, bb, ov, ev);
      check_frame($sformatf("rand%0d", i), vc, np, bb, ov, ev);
    end

    // Snapshot isolation: band 2 rewritten in cycle 3 of the mix
    band_smpl = {80'h0, 16'h0, 16'h0, 16'h1000, 16'h0, 16'h0};
    band_vld  = '1;
    pot       = {5{12'h800}};
    volume    = 12'h800;
    mute      = 1'b0;
    smpl_vld  = 1'b0;
    step();
    for (int k = 0; k <= 13; k++) begin
      smpl_vld = (k == 0);
      if (k == 3) begin
        band_smpl = {16'h0, 16'h0, 16'h4000, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0};
        band_vld  = 5'b00100;
      end else begin
        band_vld = '0;
      end
      step();
      c = k + 1;
      if (c == 13) begin
        chk("snap_f1_vld", out_vld, 1);
        chk("snap_f1_out", aud_out, 32'h0000_0800);
      end
    end
    smpl_vld = 1'b1;
    do_frame(1'b0, vc, np, bb, ov, ev);
    check_frame("snap_f2", vc, np, bb, ov, ev);
    chk("snap_f2_const", ov, 32'h2000_2000);

    // Overrun: second request in cycle 5 dropped, request in cycle 14 accepted
    p13 = 0; p27 = 0; extra = 0;
    for (int k = 0; k <= 28; k++) begin
      smpl_vld = (k == 0) || (k == 5) || (k == 14);
      step();
      c = k + 1;
      if (out_vld) begin
        if (c == 13) p13++;
        else if (c == 27) p27++;
        else extra++;
      end
      if (c == 5) chk("ovr_before", overrun, 0);
      if (c == 6) chk("ovr_set", overrun, 1);
    end
    smpl_vld = 1'b0;
    chk("ovr_pulse13", p13, 1);
    chk("ovr_accept27", p27, 1);
    chk("ovr_extra_pulses", extra, 0);
    chk("ovr_sticky", overrun, 1);

    // Reset in cycle 7 of a mix
    np = 0;
    for (int k = 0; k <= 20; k++) begin
      smpl_vld = (k == 0);
      rst = (k == 7);
      step();
      c = k + 1;
      if (out_vld) np++;
      if (c == 7) chk("rmid_busy_before", busy, 1);
      if (c == 8) begin
        chk("rmid_busy", busy, 0);
        chk("rmid_aud_out", aud_out, 0);
        chk("rmid_overrun", overrun, 0);
      end
    end
    rst = 1'b0;
    chk("rmid_no_pulse", np, 0);
    smpl_vld = 1'b1;
    do_frame(1'b0, vc, np, bb, ov, ev);
    check_frame("rmid_after", vc, np, bb, ov, ev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
